// File: rtl/ddr_maint_cmd_gen_if.sv
// Request strobes from the DDR controller and the DDR4 command bus driven by
// the maintenance sequencer.
interface ddr_maint_cmd_gen_if #(
    parameter int MRS_WIDTH = 14
);
    logic                 refresh_rdy;
    logic                 mrs_update_rdy;
    logic [MRS_WIDTH-1:0] mrs_update_cmd;
    logic                 cs_n;
    logic                 act_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [1:0]           bg;
    logic [1:0]           ba;
    logic [MRS_WIDTH-1:0] addr;
    logic                 maint_busy;
    logic                 maint_done;
    logic                 cmd_err;

    modport master (
        output refresh_rdy, mrs_update_rdy, mrs_update_cmd,
        input  cs_n, act_n, ras_n, cas_n, we_n, bg, ba, addr,
        input  maint_busy, maint_done, cmd_err
    );

    modport slave (
        input  refresh_rdy, mrs_update_rdy, mrs_update_cmd,
        output cs_n, act_n, ras_n, cas_n, we_n, bg, ba, addr,
        output maint_busy, maint_done, cmd_err
    );
endinterface

// File: rtl/ddr_maint_cmd_gen.sv
// DDR4 maintenance sequencer: PREA -> tRP -> REF -> tRFC and/or MRS(MR0) -> tMOD,
// with busy/done reporting and drop detection for requests it cannot take.
module ddr_maint_cmd_gen #(
    parameter int T_RP      = 11,
    parameter int T_RFC     = 208,
    parameter int T_MOD     = 24,
    parameter int MRS_WIDTH = 14
) (
    input  logic               clock_t,
    input  logic               reset_n,
    ddr_maint_cmd_gen_if.slave bus
);
    // Command bits ordered {cs_n, act_n, ras_n, cas_n, we_n}.
    localparam logic [4:0] CMD_DES  = 5'b11111;
    localparam logic [4:0] CMD_PREA = 5'b01010;
    localparam logic [4:0] CMD_REF  = 5'b01001;
    localparam logic [4:0] CMD_MRS  = 5'b01000;
    localparam logic [MRS_WIDTH-1:0] ADDR_A10 = MRS_WIDTH'(1) << 10;

    typedef enum logic [2:0] {
        M_IDLE, M_PREA, M_WAIT_RP, M_REF, M_WAIT_RFC, M_MRS, M_WAIT_MOD
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [4:0]           cmd_q, cmd_d;
    logic [MRS_WIDTH-1:0] addr_q, addr_d;
    logic [MRS_WIDTH-1:0] op_q, op_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 pend_q, pend_d;
    logic                 ref_q, ref_d;
    logic                 waiting, expired, finishing, mrs_owned, mrs_acc;

    assign waiting   = (state_q == M_WAIT_RP) || (state_q == M_WAIT_RFC) ||
                       (state_q == M_WAIT_MOD);
    assign expired   = waiting && (cnt_q == 16'd0) && !done_q;
    // The done cycle still counts as busy; the next edge returns to idle.
    assign finishing = waiting && (cnt_q == 16'd0) && done_q;
    assign mrs_owned = pend_q || (state_q == M_MRS) || (state_q == M_WAIT_MOD);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
        cmd_d   = CMD_DES;
        addr_d  = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pend_d  = pend_q;
        ref_d   = ref_q;
        op_d    = op_q;
        mrs_acc = 1'b0;

        if (state_q != M_IDLE) begin
            if (finishing) begin
                err_d = bus.refresh_rdy | bus.mrs_update_rdy;
            end else begin
                mrs_acc = bus.mrs_update_rdy & ~mrs_owned;
                err_d   = bus.refresh_rdy | (bus.mrs_update_rdy & mrs_owned);
                if (mrs_acc) begin
                    pend_d = 1'b1;
                    op_d   = bus.mrs_update_cmd;
                end
            end
        end

        case (state_q)
            M_IDLE: begin
                if (bus.refresh_rdy || bus.mrs_update_rdy) begin
                    state_d = M_PREA;
                    cmd_d   = CMD_PREA;
                    addr_d  = ADDR_A10;
                    busy_d  = 1'b1;
                    ref_d   = bus.refresh_rdy;
                    if (bus.mrs_update_rdy) begin
                        pend_d = 1'b1;
                        op_d   = bus.mrs_update_cmd;
                    end
                end
            end
            M_PREA: begin
                state_d = M_WAIT_RP;
                cnt_d   = 16'(T_RP - 2);
            end
            M_WAIT_RP: begin
                if (expired) begin
                    if (ref_q) begin
                        state_d = M_REF;
                        cmd_d   = CMD_REF;
                    end else begin
                        state_d = M_MRS;
                        cmd_d   = CMD_MRS;
                        addr_d  = op_q;
                        pend_d  = 1'b0;
                    end
                end
            end
            M_REF: begin
                state_d = M_WAIT_RFC;
                cnt_d   = 16'(T_RFC - 2);
                ref_d   = 1'b0;
            end
            M_WAIT_RFC: begin
                if (finishing) begin
                    state_d = M_IDLE;
                    busy_d  = 1'b0;
                end else if (expired) begin
                    // Banks are still closed after REF, so MRS follows without a PREA.
                    if (pend_q || mrs_acc) begin
                        state_d = M_MRS;
                        cmd_d   = CMD_MRS;
                        addr_d  = op_d;
                        pend_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            M_MRS: begin
                state_d = M_WAIT_MOD;
                cnt_d   = 16'(T_MOD - 2);
            end
            M_WAIT_MOD: begin
                if (finishing) begin
                    state_d = M_IDLE;
                    busy_d  = 1'b0;
                end else if (expired) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = M_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= M_IDLE;
            cnt_q   <= 16'd0;
            cmd_q   <= CMD_DES;
            addr_q  <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            ref_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            ref_q   <= ref_d;
        end
    end

    assign bus.cs_n       = cmd_q[4];
    assign bus.act_n      = cmd_q[3];
    assign bus.ras_n      = cmd_q[2];
    assign bus.cas_n      = cmd_q[1];
    assign bus.we_n       = cmd_q[0];
    assign bus.bg         = 2'b00;
    assign bus.ba         = 2'b00;
    assign bus.addr       = addr_q;
    assign bus.maint_busy = busy_q;
    assign bus.maint_done = done_q;
    assign bus.cmd_err    = err_q;
endmodule

// File: tb/tb_ddr_maint_cmd_gen.sv
// Bench for ddr_maint_cmd_gen: default-timing and minimum-timing instances,
// a schedule-based reference model, directed vectors and random requests.
module tb_ddr_maint_cmd_gen;
    localparam logic [4:0] C_DES  = 5'b11111;
    localparam logic [4:0] C_PREA = 5'b01010;
    localparam logic [4:0] C_REF  = 5'b01001;
    localparam logic [4:0] C_MRS  = 5'b01000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ddr_maint_cmd_gen_if #(.MRS_WIDTH(14)) bus0 ();
    ddr_maint_cmd_gen_if #(.MRS_WIDTH(14)) bus1 ();

    ddr_maint_cmd_gen dut0 (.clock_t(clk), .reset_n(reset_n), .bus(bus0));
    ddr_maint_cmd_gen #(.T_RP(2), .T_RFC(2), .T_MOD(2), .MRS_WIDTH(14))
        dut1 (.clock_t(clk), .reset_n(reset_n), .bus(bus1));

    // Observed outputs: {cmd[25:21], bg[20:19], ba[18:17], addr[16:3], busy, done, err}
    logic [25:0] act0, act1;
    assign act0 = {bus0.cs_n, bus0.act_n, bus0.ras_n, bus0.cas_n, bus0.we_n, bus0.bg,
                   bus0.ba, bus0.addr, bus0.maint_busy, bus0.maint_done, bus0.cmd_err};
    assign act1 = {bus1.cs_n, bus1.act_n, bus1.ras_n, bus1.cas_n, bus1.we_n, bus1.bg,
                   bus1.ba, bus1.addr, bus1.maint_busy, bus1.maint_done, bus1.cmd_err};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: each accepted request is expanded into a timetable of
    // bus events keyed by (instance, cycle).
    logic [4:0]  e_cmd  [int];
    logic [13:0] e_addr [int];
    bit          e_done [int];
    bit          e_err  [int];
    int s_start[2], s_end[2], s_ref[2], s_mrs[2];

    function automatic int key(input int i, input int c);
        return i * 1000000 + c;
    endfunction

    function automatic logic [25:0] act_of(input int i);
        return (i == 0) ? act0 : act1;
    endfunction

    function automatic logic [25:0] expv(input logic [4:0] cmd, input logic [13:0] a,
                                         input logic b, input logic d, input logic e);
        return {cmd, 2'b00, 2'b00, a, b, d, e};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, a, e);
        end
    endtask

    task automatic model_reset();
        e_cmd.delete(); e_addr.delete(); e_done.delete(); e_err.delete();
        for (int i = 0; i < 2; i++) begin
            s_start[i] = -1; s_end[i] = -1; s_ref[i] = -1; s_mrs[i] = -1;
        end
    endtask

    // Request held during cycle c; its effects appear from cycle c+1.
    task automatic model_step(input int i, input int c, input logic rf, input logic mr,
                              input logic [13:0] op);
        int trp, trfc, tmod;
        bit drop;
        trp  = (i == 0) ? 11  : 2;
        trfc = (i == 0) ? 208 : 2;
        tmod = (i == 0) ? 24  : 2;
        if (!(rf || mr)) return;
        if (s_end[i] >= 0 && c >= s_start[i] && c <= s_end[i]) begin
            drop = rf;
            if (mr) begin
                if (s_mrs[i] >= 0 || c == s_end[i]) begin
                    drop = 1'b1;
                end else begin
                    e_done.delete(key(i, s_end[i]));
                    s_mrs[i] = s_ref[i] + trfc;
                    e_cmd[key(i, s_mrs[i])]  = C_MRS;
                    e_addr[key(i, s_mrs[i])] = op;
                    s_end[i] = s_mrs[i] + tmod;
                    e_done[key(i, s_end[i])] = 1'b1;
                end
            end
            if (drop) e_err[key(i, c + 1)] = 1'b1;
        end else begin
            s_start[i] = c + 1;
            e_cmd[key(i, c + 1)]  = C_PREA;
            e_addr[key(i, c + 1)] = 14'h0400;
            if (rf) begin
                s_ref[i] = c + 1 + trp;
                e_cmd[key(i, s_ref[i])] = C_REF;
                s_mrs[i] = mr ? s_ref[i] + trfc : -1;
            end else begin
                s_ref[i] = -1;
                s_mrs[i] = c + 1 + trp;
            end
            if (s_mrs[i] >= 0) begin
                e_cmd[key(i, s_mrs[i])]  = C_MRS;
                e_addr[key(i, s_mrs[i])] = op;
                s_end[i] = s_mrs[i] + tmod;
            end else begin
                s_end[i] = s_ref[i] + trfc;
            end
            e_done[key(i, s_end[i])] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int k;
            logic [4:0]  c;
            logic [13:0] a;
            logic b, d, e;
            k = key(i, cyc);
            c = e_cmd.exists(k)  ? e_cmd[k]  : C_DES;
            a = e_addr.exists(k) ? e_addr[k] : 14'h0;
            d = e_done.exists(k);
            e = e_err.exists(k);
            b = (s_end[i] >= 0) && (cyc >= s_start[i]) && (cyc <= s_end[i]);
            cmp($sformatf("model_inst%0d", i), 32'(act_of(i)), 32'(expv(c, a, b, d, e)));
        end
    endtask

    task automatic set_in(input int i, input logic rf, input logic mr, input logic [13:0] op);
        if (i == 0) begin
            bus0.refresh_rdy = rf; bus0.mrs_update_rdy = mr; bus0.mrs_update_cmd = op;
        end else begin
            bus1.refresh_rdy = rf; bus1.mrs_update_rdy = mr; bus1.mrs_update_cmd = op;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset_n) begin
            model_step(0, cyc - 1, bus0.refresh_rdy, bus0.mrs_update_rdy, bus0.mrs_update_cmd);
            model_step(1, cyc - 1, bus1.refresh_rdy, bus1.mrs_update_rdy, bus1.mrs_update_cmd);
        end
        @(negedge clk);
        check_all();
        set_in(0, 1'b0, 1'b0, 14'h0);
        set_in(1, 1'b0, 1'b0, 14'h0);
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    typedef struct {
        int          inst;
        bit          rf;
        bit          mr;
        logic [13:0] op;
        int          ref_off;   // cycles after PREA, -1 when absent
        int          mrs_off;
        int          done_off;
    } vec_t;

    vec_t vecs[6];
    int p;
    logic [25:0] a;

    initial begin
        vecs[0] = '{0, 1'b1, 1'b0, 14'h0000, 11,  -1, 219};
        vecs[1] = '{0, 1'b0, 1'b1, 14'h0A34, -1,  11,  35};
        vecs[2] = '{0, 1'b1, 1'b1, 14'h0123, 11, 219, 243};
        vecs[3] = '{1, 1'b1, 1'b0, 14'h0000,  2,  -1,   4};
        vecs[4] = '{1, 1'b0, 1'b1, 14'h3FFF, -1,   2,   4};
        vecs[5] = '{1, 1'b1, 1'b1, 14'h1555,  2,   4,   6};

        model_reset();
        reset_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 14'h0);
        set_in(1, 1'b0, 1'b0, 14'h0);
        #12;
        cmp("reset_inst0", 32'(act0), 32'(expv(C_DES, 14'h0, 1'b0, 1'b0, 1'b0)));
        cmp("reset_inst1", 32'(act1), 32'(expv(C_DES, 14'h0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) tick();

        // Directed vectors from idle
        foreach (vecs[v]) begin
            set_in(vecs[v].inst, vecs[v].rf, vecs[v].mr, vecs[v].op);
            tick();
            p = cyc;
            for (int k = 0; k <= vecs[v].done_off + 1; k++) begin
                if (k > 0) tick();
                a = act_of(vecs[v].inst);
                if (k == 0) cmp($sformatf("vec%0d_prea", v), 32'({a[25:21], a[16:3]}),
                                32'({C_PREA, 14'h0400}));
                if (k == vecs[v].ref_off) cmp($sformatf("vec%0d_ref", v), 32'(a[25:21]), 32'(C_REF));
                if (k == vecs[v].mrs_off) cmp($sformatf("vec%0d_mrs", v),
                                              32'({a[25:17], a[16:3]}), 32'({C_MRS, 4'h0, vecs[v].op}));
                if (k == vecs[v].done_off) cmp($sformatf("vec%0d_done", v), 32'(a[2:1]), 32'(2'b11));
                if (k == vecs[v].done_off + 1) cmp($sformatf("vec%0d_idle", v), 32'(a[2:1]), 32'(2'b00));
            end
            tick(); tick();
        end

        // Duplicate refresh 50 cycles into a refresh: one error, timing unchanged
        set_in(0, 1'b1, 1'b0, 14'h0);
        tick();
        p = cyc;
        run_until(p + 50);
        set_in(0, 1'b1, 1'b0, 14'h0);
        tick();
        cmp("dup_ref_err", 32'(act0[0]), 32'd1);
        tick();
        cmp("dup_ref_err_once", 32'(act0[0]), 32'd0);
        run_until(p + 219);
        cmp("dup_ref_done", 32'(act0[1]), 32'd1);
        tick(); tick();

        // Second MRS while one is pending: dropped, first opcode kept
        set_in(0, 1'b1, 1'b0, 14'h0);
        tick();
        p = cyc;
        run_until(p + 20);
        set_in(0, 1'b0, 1'b1, 14'h1111);
        tick();
        cmp("late_mrs_no_err", 32'(act0[0]), 32'd0);
        run_until(p + 40);
        set_in(0, 1'b0, 1'b1, 14'h2222);
        tick();
        cmp("second_mrs_err", 32'(act0[0]), 32'd1);
        run_until(p + 219);
        cmp("pending_mrs_op", 32'({act0[25:21], act0[16:3]}), 32'({C_MRS, 14'h1111}));
        run_until(p + 243);
        cmp("pending_mrs_done", 32'(act0[1]), 32'd1);
        tick(); tick();

        // Request in the done cycle is dropped (minimum-timing instance)
        set_in(1, 1'b1, 1'b0, 14'h0);
        tick();
        p = cyc;
        run_until(p + 4);
        set_in(1, 1'b0, 1'b1, 14'h0ABC);
        tick();
        cmp("done_cycle_drop", 32'({act1[25:21], act1[2:0]}), 32'({C_DES, 3'b001}));
        tick(); tick(); tick();

        // Asynchronous reset during the tRFC wait, then a full restart
        set_in(0, 1'b1, 1'b0, 14'h0);
        tick();
        p = cyc;
        run_until(p + 100);
        #2 reset_n = 1'b0;
        #1;
        cmp("async_rst_inst0", 32'(act0), 32'(expv(C_DES, 14'h0, 1'b0, 1'b0, 1'b0)));
        model_reset();
        tick(); tick(); tick();
        reset_n = 1'b1;
        tick();
        set_in(0, 1'b1, 1'b0, 14'h0);
        tick();
        p = cyc;
        cmp("restart_prea", 32'({act0[25:21], act0[16:3], act0[2]}), 32'({C_PREA, 14'h0400, 1'b1}));
        run_until(p + 11);
        cmp("restart_ref", 32'(act0[25:21]), 32'(C_REF));
        run_until(p + 222);

        // Random request traffic on both instances
        for (int k = 0; k < 6000; k++) begin
            for (int i = 0; i < 2; i++) begin
                set_in(i, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                       14'($urandom));
            end
            tick();
        end
        run_until(cyc + 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_maint_cmd_gen.md
Name: ddr_maint_cmd_gen

Overview:
- Maintenance command sequencer that sits directly downstream of the DDR controller FSM.
- Consumes the controller's one-cycle refresh_rdy and mrs_update_rdy/mrs_update_cmd strobes.
- Drives DDR4 command-bus sequences with the required spacing: PREA then tRP then REF then tRFC, or PREA then tRP then MRS(MR0) then tMOD.
- Reports busy/done so the controller's update and refresh windows line up with real bus activity.

Parameters:
- T_RP, 11, precharge-all to next command spacing in clocks (minimum 2)
- T_RFC, 208, REF to next command spacing in clocks (minimum 2)
- T_MOD, 24, MRS to next command spacing in clocks (minimum 2)
- MRS_WIDTH, 14, width of mode-register opcode (A13:A0)

Ports:
- clock_t  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- refresh_rdy  input  1  one-cycle refresh request from controller
- mrs_update_rdy  input  1  one-cycle MR0 update request from controller
- mrs_update_cmd  input  MRS_WIDTH  MR0 opcode, valid when mrs_update_rdy=1
- cs_n  output  1  chip select, active low
- act_n  output  1  activate strobe, active low
- ras_n  output  1  RAS_n/A16
- cas_n  output  1  CAS_n/A15
- we_n  output  1  WE_n/A14
- bg  output  2  bank group
- ba  output  2  bank address
- addr  output  MRS_WIDTH  A13:A0
- maint_busy  output  1  high from the accepted request until the sequence completes
- maint_done  output  1  one-cycle pulse when the final timing wait expires
- cmd_err  output  1  one-cycle pulse when a request is dropped

Behaviour:
- Clock and reset: one clock (clock_t). reset_n is asynchronous and active-low.
- Reset values:
  - cs_n=act_n=ras_n=cas_n=we_n=1 (DES).
  - bg=ba=0, addr=0.
  - maint_busy=maint_done=cmd_err=0.
  - pending MRS flag cleared, counter=0, state=M_IDLE.
- All outputs are registered. Reset asserted mid-sequence aborts immediately to DES/M_IDLE. No partial command is held.
- Command encodings (one cycle each; DES every other cycle):
  - PREA: cs_n=0, act_n=1, ras_n=0, cas_n=1, we_n=0, addr[10]=1, other addr bits 0.
  - REF: cs_n=0, act_n=1, ras_n=0, cas_n=0, we_n=1, addr=0.
  - MRS: cs_n=0, act_n=1, ras_n=0, cas_n=0, we_n=0, bg=0, ba=0, addr=latched opcode.
- States: M_IDLE, M_PREA, M_WAIT_RP, M_REF, M_WAIT_RFC, M_MRS, M_WAIT_MOD.
- M_IDLE:
  - refresh_rdy=1 at edge E: PREA is on the bus in cycle E+1 and maint_busy=1 from E+1. This takes priority over MRS.
  - else mrs_update_rdy=1: latch mrs_update_cmd and go to PREA the same way.
- M_PREA to M_WAIT_RP: counter loads T_RP-2. The next command (REF or MRS) is on the bus exactly T_RP cycles after PREA.
- M_REF to M_WAIT_RFC: on expiry, maint_done pulses in cycle REF+T_RFC.
  - If an MRS is pending, MRS is issued in that same cycle instead of the done pulse. No second PREA, since banks are already closed.
- M_MRS to M_WAIT_MOD: maint_done pulses in cycle MRS+T_MOD. maint_busy drops in the cycle after maint_done. Return to M_IDLE.
- Simultaneous refresh_rdy and mrs_update_rdy in M_IDLE: refresh is serviced and the MRS opcode is latched as pending. Sequence is PREA, REF, then MRS.
- Requests while busy:
  - mrs_update_rdy with no MRS pending or in progress: latched as pending, serviced after the current REF.
  - Any other request while busy (refresh_rdy, or a second MRS): dropped, cmd_err pulses for 1 cycle in the following cycle.
- A request arriving in the same cycle maint_done pulses is treated as busy. The rule is deterministic, so the controller must wait for maint_busy=0.
- Counter is 16-bit, down-counting, with no wrap. It saturates at 0, and expiry means counter==0 in a wait state.

Test Plan:
- Reset, then refresh_rdy pulse at cycle 10 -> PREA at cycle 11 (addr[10]=1), REF at 22, maint_done at 230, maint_busy high cycles 11-230 and low at 231, DES on all other cycles.
- mrs_update_rdy with mrs_update_cmd=14'h0A34 -> PREA at t+1, MRS at t+12 with bg=ba=0 and addr=14'h0A34, maint_done at t+36.
- refresh_rdy and mrs_update_rdy (14'h0123) in the same cycle -> PREA, REF 11 later, MRS with 14'h0123 208 after REF, maint_done 24 after MRS; exactly one PREA.
- refresh_rdy again 50 cycles into a refresh sequence -> cmd_err pulses once and the sequence timing is unchanged. A second mrs_update_rdy while one is pending -> cmd_err, and the first opcode is retained.
- reset_n low during M_WAIT_RFC -> outputs go to DES/0 asynchronously. After release, refresh_rdy restarts a full PREA/REF sequence.
- Override T_RP=2, T_RFC=2, T_MOD=2 -> PREA, REF, and done are each spaced by 2 cycles, with no off-by-one at the minimum values.
